// File: rtl/dual_port_bram_clr_if.sv
// rtl/dual_port_bram_clr_if.sv - read/write/clear bus of the clearable dual-port block RAM
interface dual_port_bram_clr_if #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 9,
    parameter int BYTE_WIDTH    = 8
);
    localparam int NB = RAM_WIDTH / BYTE_WIDTH;

    logic                     clear;
    logic                     busy;
    logic                     rd_en;
    logic [RAM_ADDR_BITS-1:0] rd_addr;
    logic [RAM_WIDTH-1:0]     rd_data;
    logic                     rd_valid;
    logic                     write_enable;
    logic [RAM_ADDR_BITS-1:0] wr_addr;
    logic [RAM_WIDTH-1:0]     wr_data;
    logic [NB-1:0]            wr_be;

    modport master (
        output clear, rd_en, rd_addr, write_enable, wr_addr, wr_data, wr_be,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clear, rd_en, rd_addr, write_enable, wr_addr, wr_data, wr_be,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/dual_port_bram_clr.sv
// rtl/dual_port_bram_clr.sv - dual-port block RAM with byte enables and a background clear sweep
module dual_port_bram_clr #(
    parameter int                   RAM_WIDTH     = 16,
    parameter int                   RAM_ADDR_BITS = 9,
    parameter int                   BYTE_WIDTH    = 8,
    parameter int                   READ_LATENCY  = 1,
    parameter int                   BYPASS        = 0,
    parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input logic                clk,
    input logic                rst,
    dual_port_bram_clr_if.slave bus
);
    localparam int NB    = RAM_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** RAM_ADDR_BITS;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

    logic [RAM_WIDTH-1:0]     mem [DEPTH];
    logic [0:0]               state;
    logic [RAM_ADDR_BITS-1:0] sweep_addr;
    logic                     rd_fire;
    logic                     wr_fire;
    logic [RAM_WIDTH-1:0]     rd_word;
    logic [RAM_WIDTH-1:0]     rd_data_q;
    logic                     rd_valid_q;

    assign rd_fire = !rst && (state == S_IDLE) && bus.rd_en;
    assign wr_fire = !rst && (state == S_IDLE) && bus.write_enable;

    // Write-first merges the enabled bytes of a same-edge write into the read word.
    always_comb begin
        rd_word = mem[bus.rd_addr];
        if ((BYPASS != 0) && wr_fire && (bus.wr_addr == bus.rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wr_be[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Reset parks the sweep at address 0, so memory is re-cleared once rst falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_SWEEP;
            sweep_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.clear) begin
                        state      <= S_SWEEP;
                        sweep_addr <= '0;
                    end
                end
                default: begin
                    if (bus.clear) begin
                        sweep_addr <= '0;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                        if (sweep_addr == LAST_ADDR) begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_SWEEP) begin
                mem[sweep_addr] <= CLEAR_VALUE;
            end else if (wr_fire) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.wr_be[i]) begin
                        mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [RAM_WIDTH-1:0] s1_data;
            logic                 s1_valid;

            // The second stage drains regardless of state so in-flight reads survive a sweep start.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_data    <= '0;
                    s1_valid   <= 1'b0;
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    s1_valid <= rd_fire;
                    if (rd_fire) begin
                        s1_data <= rd_word;
                    end
                    rd_valid_q <= s1_valid;
                    if (s1_valid) begin
                        rd_data_q <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_fire;
                    if (rd_fire) begin
                        rd_data_q <= rd_word;
                    end
                end
            end
        end
    endgenerate

    assign bus.busy     = (state == S_SWEEP);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: doc/dual_port_bram_clr.md
DUAL_PORT_BRAM_CLR -- requirements
Module: dual_port_bram_clr

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 9: address width; depth = 2**RAM_ADDR_BITS.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: write-enable granule; RAM_WIDTH shall be an integer multiple of it; NB = RAM_WIDTH/BYTE_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1: legal values 1 or 2 (2 adds an output register).
REQ-005 SHALL have parameter BYPASS, default 0: 0 = read-first on address collision, 1 = write-first.
REQ-006 SHALL have parameter CLEAR_VALUE, default 0: RAM_WIDTH-bit word written by every sweep.
REQ-007 Ports: clk  in  1  single clock; all logic on its rising edge.
REQ-008 Ports: rst  in  1  reset, synchronous and active-high.
REQ-009 Ports: clear  in  1  one-cycle request to start a memory sweep.
REQ-010 Ports: busy  out  1  high while a sweep is in progress.
REQ-011 Ports: rd_en  in  1  read request; rd_addr  in  RAM_ADDR_BITS  read address.
REQ-012 Ports: rd_data  out  RAM_WIDTH  read data; rd_valid  out  1  rd_data updated this cycle.
REQ-013 Ports: write_enable  in  1; wr_addr  in  RAM_ADDR_BITS; wr_data  in  RAM_WIDTH; wr_be  in  NB  per-byte write mask.

Function
REQ-014 SHALL implement a two-state machine IDLE/SWEEP with an RAM_ADDR_BITS-bit sweep counter.
REQ-015 SWEEP: one word per cycle, CLEAR_VALUE written at counter address, counter 0 -> 2**RAM_ADDR_BITS-1; exactly 2**RAM_ADDR_BITS cycles; -> IDLE the cycle after the last address is written.
REQ-016 IDLE -> SWEEP the cycle after clear=1; clear=1 during SWEEP SHALL restart the counter at 0.
REQ-017 busy SHALL equal (state == SWEEP), registered.
REQ-018 During SWEEP, write_enable SHALL be ignored (no memory change beyond the sweep write); no error flag.
REQ-019 During SWEEP, rd_en SHALL be ignored: rd_valid stays 0, rd_data holds its value.
REQ-020 IDLE write: for each byte i with wr_be[i]=1, byte i of word wr_addr takes wr_data byte i; other bytes unchanged; write_enable with wr_be=0 is a no-op.
REQ-021 IDLE read: rd_en=1 at edge N SHALL give rd_data and rd_valid=1 at edge N+READ_LATENCY; reads fully pipelined, one per cycle.
REQ-022 rd_valid SHALL be 0 in any cycle without a matching read; rd_data SHALL hold the last read value otherwise.
REQ-023 Collision (rd_en, write_enable, rd_addr==wr_addr, same edge): BYPASS=0 returns pre-write word; BYPASS=1 returns the post-write word (enabled bytes new, others old).
REQ-024 A read issued the edge after a write to the same address SHALL return the written data for either BYPASS setting.
REQ-025 Reads already in flight when a sweep starts SHALL complete with data sampled at their issue edge.

Reset
REQ-026 rst=1 at an edge SHALL set rd_data=0, rd_valid=0, drop in-flight reads, clear pipeline registers, counter=0, state=SWEEP.
REQ-027 While rst=1, state SHALL stay SWEEP with counter held at 0 and busy=1; the sweep proceeds from address 0 after rst falls, so memory holds CLEAR_VALUE everywhere after 2**RAM_ADDR_BITS further cycles.
REQ-028 rst mid-sweep or mid-read SHALL behave identically to REQ-026/027; clear is ignored while rst=1.
REQ-029 Memory contents SHALL not be reset in a single cycle; initialisation is only via the sweep.

Verification
REQ-030 Release rst -> busy=1 for exactly 512 cycles (defaults), then 0; reads of addresses 0, 255, 511 return 0x0000 with rd_valid one cycle later.
REQ-031 Write 0xABCD to 0x010 with wr_be=2'b01, after word held 0x1234 -> read returns 0x12CD; wr_be=2'b10 with 0xFF00 -> 0xFFCD.
REQ-032 Collision: word 0x005 = 0x1111, same-edge write 0x2222 and read of 0x005 -> BYPASS=0 returns 0x1111, BYPASS=1 returns 0x2222; next-cycle read returns 0x2222 in both.
REQ-033 READ_LATENCY=2: back-to-back reads of 0..7 -> rd_valid high 8 consecutive cycles starting 2 cycles after the first rd_en, data in address order.
REQ-034 clear pulse, second clear 100 cycles later -> busy stays high 612 cycles total; writes/reads during busy have no effect and produce rd_valid=0; afterwards all words equal CLEAR_VALUE.
REQ-035 rst asserted at sweep address 300 for 3 cycles -> rd_valid=0, rd_data=0, busy=1 throughout; full 512-cycle sweep from address 0 after release.
